// File: rtl/kbd_pkg.sv
// Shared constants, types and helpers for the 4x4 keypad scan controller.
package kbd_pkg;

  localparam int KBD_ROWS = 4;
  localparam int KBD_COLS = 4;
  localparam int KBD_KEYS = 16;

  typedef logic [4:0] key_code_t;

  typedef enum logic {
    SCAN,
    EMIT
  } scan_state_e;

  function automatic logic [3:0] key_index(
    input logic [1:0] row,
    input logic [1:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Synchronous event FIFO: push with drop-on-full (sticky overflow),
// valid/ready pop from the registered head entry.
module kbd_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             r_ovf;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && i_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO lands.
  assign w_wr    = i_push && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[AW-1:0]] <= i_data;
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
      if (i_push && !w_wr) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign o_valid    = !w_empty;
  assign o_data     = r_mem[r_rptr[AW-1:0]];
  assign o_overflow = r_ovf;

endmodule

// File: rtl/kbd_scan_ctrl.sv
// 4x4 keypad scanner: row strobing, per-frame debounce, key-event stream.
// Define KBD_RELEASE_EVENTS_EN to also emit release events.
module kbd_scan_ctrl
  import kbd_pkg::*;
#(
  parameter int CLK_FREQ        = 25_000_000,
  parameter int ROW_HZ          = 1_000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [KBD_COLS-1:0] column_i,
  output logic [KBD_ROWS-1:0] row_o,
  output key_code_t           key_code_o,
  output logic                key_valid_o,
  input  logic                key_ready_i,
  output logic [KBD_KEYS-1:0] pressed_o,
  output logic                overflow_o
);

  localparam int DWELL = CLK_FREQ / ROW_HZ;
  localparam int DW    = $clog2(DWELL);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [3:0]    DB_LIM     = 4'(DEBOUNCE_FRAMES);

  if (DWELL < 8) begin : g_dwell_chk
    $error("kbd_scan_ctrl: CLK_FREQ/ROW_HZ must be >= 8");
  end
  if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_deb_chk
    $error("kbd_scan_ctrl: DEBOUNCE_FRAMES must be 1..15");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fifo_chk
    $error("kbd_scan_ctrl: FIFO_DEPTH must be a power of two >= 2");
  end

  scan_state_e         r_state;
  scan_state_e         w_state_nxt;
  logic [KBD_COLS-1:0] r_col_s1;
  logic [KBD_COLS-1:0] r_col_s2;
  logic [KBD_COLS-1:0] w_col;
  logic [DW-1:0]       r_dwell;
  logic [1:0]          r_row_idx;
  logic [1:0]          w_row_nxt;
  logic [KBD_ROWS-1:0] r_row;
  logic [KBD_KEYS-1:0] r_raw;
  logic [KBD_KEYS-1:0] w_raw_frame;
  logic [KBD_KEYS-1:0] r_pressed;
  logic [KBD_KEYS-1:0] r_pending;
  logic [3:0]          r_cnt [KBD_KEYS];
  logic [3:0]          r_emit_idx;
  logic                w_dwell_end;
  logic                w_frame_end;
  logic                w_push;
  key_code_t           w_push_code;

  assign w_col       = ~r_col_s2;
  assign w_dwell_end = (r_dwell == DWELL_LAST);
  assign w_frame_end = w_dwell_end && (r_row_idx == 2'd3);
  assign w_row_nxt   = w_dwell_end ? r_row_idx + 2'd1 : r_row_idx;

  // Raw frame including the row being sampled this cycle.
  always_comb begin
    w_raw_frame = r_raw;
    w_raw_frame[key_index(r_row_idx, 2'd0) +: KBD_COLS] = w_col;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_col_s1  <= '1;
      r_col_s2  <= '1;
      r_dwell   <= '0;
      r_row_idx <= '0;
      r_row     <= '1;
      r_raw     <= '0;
    end else begin
      r_col_s1  <= column_i;
      r_col_s2  <= r_col_s1;
      r_dwell   <= w_dwell_end ? '0 : r_dwell + DW'(1);
      r_row_idx <= w_row_nxt;
      r_row     <= ~(4'b0001 << w_row_nxt);
      if (w_dwell_end) begin
        r_raw <= w_raw_frame;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pressed <= '0;
      r_pending <= '0;
      for (int k = 0; k < KBD_KEYS; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      if (r_state == EMIT) begin
        r_pending[r_emit_idx] <= 1'b0;
      end
      if (w_frame_end && r_state == SCAN) begin
        for (int k = 0; k < KBD_KEYS; k++) begin
          if (w_raw_frame[k] != r_pressed[k]) begin
            if (r_cnt[k] + 4'd1 == DB_LIM) begin
              r_pressed[k] <= ~r_pressed[k];
              r_pending[k] <= 1'b1;
              r_cnt[k]     <= '0;
            end else begin
              r_cnt[k] <= r_cnt[k] + 4'd1;
            end
          end else begin
            r_cnt[k] <= '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= SCAN;
      r_emit_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_emit_idx <= (r_state == EMIT) ? r_emit_idx + 4'd1 : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_code = '0;
    unique case (r_state)
      SCAN: begin
        if (w_frame_end) begin
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (r_pending[r_emit_idx]) begin
`ifdef KBD_RELEASE_EVENTS_EN
          w_push      = 1'b1;
          w_push_code = {~r_pressed[r_emit_idx], r_emit_idx};
`else
          w_push      = r_pressed[r_emit_idx];
          w_push_code = {1'b0, r_emit_idx};
`endif
        end
        if (r_emit_idx == 4'd15) begin
          w_state_nxt = SCAN;
        end
      end
      default: w_state_nxt = SCAN;
    endcase
  end

  kbd_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (5)
  ) u_fifo (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_push     (w_push),
    .i_data     (w_push_code),
    .o_valid    (key_valid_o),
    .i_ready    (key_ready_i),
    .o_data     (key_code_o),
    .o_overflow (overflow_o)
  );

  assign row_o     = r_row;
  assign pressed_o = r_pressed;

endmodule
